wall_spawn_controller: RTL and testbench

Sequences the wall height generator and owns the on-screen wall set for the game. Issues a height request every SPAWN_TICKS frame ticks, places the returned height into a free wall slot at the right screen edge, and scrolls all active walls left by STEP pixels per frame tick. It sits between the frame timer, the wall height generator and the renderer/collision logic, which read its slot outputs.

---
 rtl/wall_spawn_controller_pkg.sv | 23 ++
 rtl/wall_spawn_controller_slot.sv | 52 +++++
 rtl/wall_spawn_controller.sv | 137 +++++++++++++
 tb/tb_wall_spawn_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wall_spawn_controller_pkg.sv
// Shared wall definitions: FSM encodings, slot count and default geometry/timing.
// The height generator and renderer import this package as well.
package wall_defs;

    localparam int NUM_SLOTS       = 3;
    localparam int SCREEN_W_DEF    = 160;
    localparam int STEP_DEF        = 1;
    localparam int SPAWN_TICKS_DEF = 54;
    localparam int BIRD_X_DEF      = 40;
    localparam int MAX_H_DEF       = 93;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SPAWN = 2'd2
    } state_t;

    // Saturate a generator height at the ceiling (8-bit unsigned compare).
    function automatic logic [7:0] clamp_height(input logic [7:0] h, input logic [7:0] max_h);
        return (h > max_h) ? max_h : h;
    endfunction

endpackage

// File: rtl/wall_spawn_controller_slot.sv
// One on-screen wall: position, height and valid bit, with load, scroll and
// crossing detection against the bird column.
module wall_slot
    import wall_defs::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int STEP     = STEP_DEF,
    parameter int BIRD_X   = BIRD_X_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_h,
    input  logic       scroll,
    output logic       active,
    output logic [7:0] x,
    output logic [7:0] h,
    output logic       crossed
);

    localparam logic [7:0] X_SPAWN = 8'(SCREEN_W - 1);
    localparam logic [7:0] STEP_W  = 8'(STEP);
    localparam logic [7:0] BIRD_W  = 8'(BIRD_X);

    logic [7:0] x_next;

    // A wall crosses when this scroll moves it from at/right of the bird to left of it.
    always_comb begin
        x_next  = x - STEP_W;
        crossed = scroll && active && (x >= STEP_W) && (x >= BIRD_W) && (x_next < BIRD_W);
    end

    // Load a fresh wall at the right edge, otherwise scroll or retire an active one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            x      <= 8'd0;
            h      <= 8'd0;
        end else if (load) begin
            active <= 1'b1;
            x      <= X_SPAWN;
            h      <= load_h;
        end else if (scroll && active) begin
            if (x < STEP_W) begin
                active <= 1'b0;
            end else begin
                x <= x_next;
            end
        end
    end

endmodule

// File: rtl/wall_spawn_controller.sv
// Wall spawn controller: paces height requests from the frame tick, hands the
// returned height to the lowest free slot and scrolls all walls each tick.
module wall_spawn_controller
    import wall_defs::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int SPAWN_TICKS = SPAWN_TICKS_DEF,
    parameter int BIRD_X      = BIRD_X_DEF,
    parameter int MAX_H       = MAX_H_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       tick,
    output logic       gen_req,
    input  logic       gen_ack,
    input  logic [7:0] gen_height,
    output logic [2:0] wall_active,
    output logic [7:0] wall_x0,
    output logic [7:0] wall_x1,
    output logic [7:0] wall_x2,
    output logic [7:0] wall_h0,
    output logic [7:0] wall_h1,
    output logic [7:0] wall_h2,
    output logic       wall_passed
);

    localparam logic [5:0] CNT_LAST = 6'(SPAWN_TICKS - 1);
    localparam logic [7:0] MAX_H_W  = 8'(MAX_H);

    state_t     state;
    state_t     next_state;
    logic [5:0] spawn_cnt;
    logic       tick_pending;
    logic       run_tick;
    logic       spawn_hit;
    logic       gen_req_next;
    logic [2:0] free_sel;
    logic [2:0] load_vec;
    logic [2:0] crossed;
    logic [7:0] clamped_h;
    logic [7:0] slot_x [NUM_SLOTS];
    logic [7:0] slot_h [NUM_SLOTS];

    // Lowest-index inactive slot, one-hot; zero when every slot is occupied.
    always_comb begin
        free_sel = 3'b000;
        if (!wall_active[0]) begin
            free_sel = 3'b001;
        end else if (!wall_active[1]) begin
            free_sel = 3'b010;
        end else if (!wall_active[2]) begin
            free_sel = 3'b100;
        end
    end

    // Next state, effective tick, slot load strobes and the next request level.
    always_comb begin
        next_state   = state;
        run_tick     = (state == RUN) && enable && (tick || tick_pending);
        spawn_hit    = run_tick && (spawn_cnt == CNT_LAST);
        load_vec     = 3'b000;
        clamped_h    = clamp_height(gen_height, MAX_H_W);
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (spawn_hit && (free_sel != 3'b000)) begin
                    next_state = SPAWN;
                end
            end
            SPAWN: begin
                if (gen_ack) begin
                    load_vec   = free_sel;
                    next_state = enable ? RUN : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        gen_req_next = (next_state == SPAWN);
    end

    // State, request, spawn pacing, held tick and the merged crossing pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            gen_req      <= 1'b0;
            spawn_cnt    <= 6'd0;
            tick_pending <= 1'b0;
            wall_passed  <= 1'b0;
        end else begin
            state       <= next_state;
            gen_req     <= gen_req_next;
            wall_passed <= |crossed;
            if (run_tick) begin
                spawn_cnt <= spawn_hit ? 6'd0 : spawn_cnt + 6'd1;
            end
            if ((state == SPAWN) && tick) begin
                tick_pending <= 1'b1;
            end else if (run_tick) begin
                tick_pending <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        wall_slot #(
            .SCREEN_W (SCREEN_W),
            .STEP     (STEP),
            .BIRD_X   (BIRD_X)
        ) u_slot (
            .clk      (clk),
            .resetn   (resetn),
            .load     (load_vec[i]),
            .load_h   (clamped_h),
            .scroll   (run_tick),
            .active   (wall_active[i]),
            .x        (slot_x[i]),
            .h        (slot_h[i]),
            .crossed  (crossed[i])
        );
    end

    assign wall_x0 = slot_x[0];
    assign wall_x1 = slot_x[1];
    assign wall_x2 = slot_x[2];
    assign wall_h0 = slot_h[0];
    assign wall_h1 = slot_h[1];
    assign wall_h2 = slot_h[2];

endmodule

// File: tb/tb_wall_spawn_controller.sv
// Directed bench for wall_spawn_controller: a default-parameter instance for
// the main scenarios and a fast-spawning instance to fill every slot.
module tb_wall_spawn_controller;
    import wall_defs::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic       gen_ack = 1'b0;
    logic [7:0] gen_height = 8'd0;
    logic       gen_req;
    logic [2:0] wall_active;
    logic [7:0] wall_x0, wall_x1, wall_x2, wall_h0, wall_h1, wall_h2;
    logic       wall_passed;

    logic       enable_s = 1'b0;
    logic       tick_s = 1'b0;
    logic       gen_ack_s = 1'b0;
    logic       gen_req_s;
    logic [2:0] wall_active_s;
    logic [7:0] wall_x0_s, wall_x1_s, wall_x2_s, wall_h0_s, wall_h1_s, wall_h2_s;
    logic       wall_passed_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wall_spawn_controller u_main (
        .clk(clk), .resetn(resetn), .enable(enable), .tick(tick),
        .gen_req(gen_req), .gen_ack(gen_ack), .gen_height(gen_height),
        .wall_active(wall_active),
        .wall_x0(wall_x0), .wall_x1(wall_x1), .wall_x2(wall_x2),
        .wall_h0(wall_h0), .wall_h1(wall_h1), .wall_h2(wall_h2),
        .wall_passed(wall_passed)
    );

    wall_spawn_controller #(.SPAWN_TICKS(4)) u_small (
        .clk(clk), .resetn(resetn), .enable(enable_s), .tick(tick_s),
        .gen_req(gen_req_s), .gen_ack(gen_ack_s), .gen_height(gen_height),
        .wall_active(wall_active_s),
        .wall_x0(wall_x0_s), .wall_x1(wall_x1_s), .wall_x2(wall_x2_s),
        .wall_h0(wall_h0_s), .wall_h1(wall_h1_s), .wall_h2(wall_h2_s),
        .wall_passed(wall_passed_s)
    );

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] h);
        gen_height = h;
        gen_ack = 1'b1;
        @(posedge clk);
        #1;
        gen_ack = 1'b0;
    endtask

    task automatic tick_run(input int n, input logic [7:0] h);
        for (int i = 0; i < n; i++) begin
            do_tick();
            if (gen_req === 1'b1) do_ack(h);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (gen_req !== 1'b0) begin failures++; $display("FAIL reset_gen_req: got %0b expected 0", gen_req); end
        checks++; if (wall_active !== 3'b000) begin failures++; $display("FAIL reset_active: got %b expected 000", wall_active); end
        checks++; if ({wall_x0, wall_x1, wall_x2, wall_h0, wall_h1, wall_h2} !== 48'h0) begin failures++; $display("FAIL reset_xh: got %h expected 0", {wall_x0, wall_x1, wall_x2, wall_h0, wall_h1, wall_h2}); end
        checks++; if (wall_passed !== 1'b0) begin failures++; $display("FAIL reset_passed: got %0b expected 0", wall_passed); end
        checks++; if ({gen_req_s, wall_active_s} !== 4'b0000) begin failures++; $display("FAIL reset_small: got %b expected 0000", {gen_req_s, wall_active_s}); end
        @(negedge clk);
        resetn = 1'b1;
        idle_cycle();
    endtask

    task automatic test_spawn();
        enable = 1'b1;
        idle_cycle();
        for (int i = 0; i < 53; i++) begin
            do_tick();
            checks++; if (gen_req !== 1'b0) begin failures++; $display("FAIL early_req tick %0d: got %0b expected 0", i + 1, gen_req); end
        end
        do_tick();
        checks++; if (gen_req !== 1'b1) begin failures++; $display("FAIL spawn_req: got %0b expected 1", gen_req); end
        do_ack(8'd60);
        checks++; if (gen_req !== 1'b0) begin failures++; $display("FAIL req_drop: got %0b expected 0", gen_req); end
        checks++; if (wall_active !== 3'b001) begin failures++; $display("FAIL spawn_active: got %b expected 001", wall_active); end
        checks++; if (wall_x0 !== 8'd159) begin failures++; $display("FAIL spawn_x0: got %0d expected 159", wall_x0); end
        checks++; if (wall_h0 !== 8'd60) begin failures++; $display("FAIL spawn_h0: got %0d expected 60", wall_h0); end
    endtask

    task automatic test_clamp();
        tick_run(54, 8'd200);
        checks++; if (wall_active !== 3'b011) begin failures++; $display("FAIL clamp_active: got %b expected 011", wall_active); end
        checks++; if (wall_x1 !== 8'd159) begin failures++; $display("FAIL clamp_x1: got %0d expected 159", wall_x1); end
        checks++; if (wall_h1 !== 8'd93) begin failures++; $display("FAIL clamp_h1: got %0d expected 93", wall_h1); end
        checks++; if (wall_x0 !== 8'd105) begin failures++; $display("FAIL scroll_x0: got %0d expected 105", wall_x0); end
    endtask

    task automatic test_passed();
        tick_run(65, 8'd70);
        checks++; if ({wall_x0, wall_x1, wall_x2} !== {8'd40, 8'd94, 8'd148}) begin failures++; $display("FAIL pre_cross_x: got %0d %0d %0d expected 40 94 148", wall_x0, wall_x1, wall_x2); end
        checks++; if (wall_h2 !== 8'd70) begin failures++; $display("FAIL h2: got %0d expected 70", wall_h2); end
        checks++; if (wall_passed !== 1'b0) begin failures++; $display("FAIL pre_cross_pulse: got %0b expected 0", wall_passed); end
        do_tick();
        checks++; if (wall_x0 !== 8'd39) begin failures++; $display("FAIL cross_x0: got %0d expected 39", wall_x0); end
        checks++; if (wall_passed !== 1'b1) begin failures++; $display("FAIL cross_pulse: got %0b expected 1", wall_passed); end
        idle_cycle();
        checks++; if (wall_passed !== 1'b0) begin failures++; $display("FAIL pulse_width: got %0b expected 0", wall_passed); end
    endtask

    task automatic test_expire();
        tick_run(39, 8'd0);
        checks++; if ({wall_active, wall_x0} !== {3'b111, 8'd0}) begin failures++; $display("FAIL edge_x0: got %b %0d expected 111 0", wall_active, wall_x0); end
        do_tick();
        checks++; if (wall_active !== 3'b110) begin failures++; $display("FAIL expire_active: got %b expected 110", wall_active); end
        checks++; if ({wall_x0, wall_h0} !== {8'd0, 8'd60}) begin failures++; $display("FAIL expire_stale: got %0d %0d expected 0 60", wall_x0, wall_h0); end
        checks++; if (wall_passed !== 1'b0) begin failures++; $display("FAIL expire_pulse: got %0b expected 0", wall_passed); end
    endtask

    task automatic test_pending();
        do_tick();
        do_tick();
        checks++; if (gen_req !== 1'b1) begin failures++; $display("FAIL pend_req: got %0b expected 1", gen_req); end
        for (int i = 0; i < 10; i++) begin
            tick = (i == 2 || i == 5);
            idle_cycle();
        end
        tick = 1'b0;
        checks++; if ({gen_req, wall_x1, wall_x2} !== {1'b1, 8'd51, 8'd105}) begin failures++; $display("FAIL spawn_frozen: got %0b %0d %0d expected 1 51 105", gen_req, wall_x1, wall_x2); end
        do_ack(8'd50);
        checks++; if ({wall_active, wall_x0, wall_h0, wall_x1} !== {3'b111, 8'd159, 8'd50, 8'd51}) begin failures++; $display("FAIL pend_load: got %b %0d %0d %0d expected 111 159 50 51", wall_active, wall_x0, wall_h0, wall_x1); end
        idle_cycle();
        checks++; if ({wall_x0, wall_x1, wall_x2} !== {8'd158, 8'd50, 8'd104}) begin failures++; $display("FAIL pend_scroll: got %0d %0d %0d expected 158 50 104", wall_x0, wall_x1, wall_x2); end
        idle_cycle();
        checks++; if ({wall_x0, wall_x1} !== {8'd158, 8'd50}) begin failures++; $display("FAIL pend_once: got %0d %0d expected 158 50", wall_x0, wall_x1); end
    endtask

    task automatic test_reset_mid_spawn();
        for (int i = 0; i < 53; i++) do_tick();
        checks++; if (gen_req !== 1'b1) begin failures++; $display("FAIL pend_counted_req: got %0b expected 1", gen_req); end
        idle_cycle();
        idle_cycle();
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (gen_req !== 1'b0) begin failures++; $display("FAIL async_req: got %0b expected 0", gen_req); end
        checks++; if ({wall_active, wall_x0, wall_x1, wall_x2, wall_h0, wall_h1, wall_h2, wall_passed} !== 52'h0) begin failures++; $display("FAIL async_outputs: got %h expected 0", {wall_active, wall_x0, wall_x1, wall_x2, wall_h0, wall_h1, wall_h2, wall_passed}); end
        @(negedge clk);
        resetn = 1'b1;
        idle_cycle();
    endtask

    task automatic test_enable_freeze();
        idle_cycle();
        for (int i = 0; i < 54; i++) do_tick();
        checks++; if (gen_req !== 1'b1) begin failures++; $display("FAIL freeze_req: got %0b expected 1", gen_req); end
        enable = 1'b0;
        idle_cycle();
        checks++; if (gen_req !== 1'b1) begin failures++; $display("FAIL hold_req: got %0b expected 1", gen_req); end
        do_ack(8'd30);
        checks++; if ({gen_req, wall_active, wall_x0, wall_h0} !== {1'b0, 3'b001, 8'd159, 8'd30}) begin failures++; $display("FAIL freeze_load: got %0b %b %0d %0d expected 0 001 159 30", gen_req, wall_active, wall_x0, wall_h0); end
        checks++; if (u_main.state !== IDLE) begin failures++; $display("FAIL freeze_state: got %0d expected 0", u_main.state); end
        for (int i = 0; i < 5; i++) do_tick();
        checks++; if ({gen_req, wall_x0} !== {1'b0, 8'd159}) begin failures++; $display("FAIL idle_hold: got %0b %0d expected 0 159", gen_req, wall_x0); end
        enable = 1'b1;
        idle_cycle();
        do_tick();
        checks++; if (wall_x0 !== 8'd158) begin failures++; $display("FAIL resume_x0: got %0d expected 158", wall_x0); end
    endtask

    task automatic test_full_slots();
        enable_s = 1'b1;
        idle_cycle();
        for (int t = 0; t < 16; t++) begin
            tick_s = 1'b1;
            idle_cycle();
            tick_s = 1'b0;
            if (gen_req_s === 1'b1) begin
                gen_height = 8'd10;
                gen_ack_s = 1'b1;
                idle_cycle();
                gen_ack_s = 1'b0;
            end
        end
        checks++; if ({gen_req_s, wall_active_s} !== {1'b0, 3'b111}) begin failures++; $display("FAIL full_skip: got %0b %b expected 0 111", gen_req_s, wall_active_s); end
        checks++; if ({wall_x0_s, wall_x1_s, wall_x2_s} !== {8'd147, 8'd151, 8'd155}) begin failures++; $display("FAIL full_x: got %0d %0d %0d expected 147 151 155", wall_x0_s, wall_x1_s, wall_x2_s); end
        checks++; if ({wall_h0_s, wall_h1_s, wall_h2_s, wall_passed_s} !== {8'd10, 8'd10, 8'd10, 1'b0}) begin failures++; $display("FAIL full_h: got %0d %0d %0d %0b expected 10 10 10 0", wall_h0_s, wall_h1_s, wall_h2_s, wall_passed_s); end
        checks++; if (u_small.spawn_cnt !== 6'd0) begin failures++; $display("FAIL full_cnt: got %0d expected 0", u_small.spawn_cnt); end
        checks++; if (u_small.state !== RUN) begin failures++; $display("FAIL full_state: got %0d expected 1", u_small.state); end
        idle_cycle();
        checks++; if (gen_req_s !== 1'b0) begin failures++; $display("FAIL full_no_req: got %0b expected 0", gen_req_s); end
    endtask

    // Scenarios run in order; each builds on the wall positions left by the previous one.
    initial begin
        test_reset();
        test_spawn();
        test_clamp();
        test_passed();
        test_expire();
        test_pending();
        test_reset_mid_spawn();
        test_enable_freeze();
        test_full_slots();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
